// File: rtl/pmm_stream_matcher.sv
`timescale 1ns/1ps
// pmm_stream_matcher: extended shift-and NFA matcher with a command/data
// front end. Tables (REP_POS/MOVE per symbol plus five control words) are
// written word-by-word; each MATCH advances the persistent NFA state by one
// symbol (alpha step, then epsilon closure) and reports acceptance.
module pmm_stream_matcher #(
    parameter int STATE_W    = 64,
    parameter int CHAR_W     = 8,
    parameter int ADDR_SHIFT = 3,
    parameter int CNT_W      = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [STATE_W-1:0] inp_data,
    input  logic [15:0]        inp_control,
    input  logic               data_valid,
    output logic               ready_status,
    output logic               done_status,
    output logic               accepted_status,
    output logic               error_status,
    output logic [CNT_W-1:0]   match_count
);

    // Derived sizes. The word index must be wide enough to address a
    // per-symbol table entry, and the data word must carry a full symbol.
    localparam int NSYM  = 1 << CHAR_W;
    localparam int DEPTH = 2 * NSYM + 5;
    localparam int IDX_W = 14 - ADDR_SHIFT;
    localparam int N_CTL = 5;

    localparam logic [31:0] NSYM_U  = 32'(NSYM);
    localparam logic [31:0] TBL_END = 32'(2 * NSYM);
    localparam logic [31:0] DEPTH_U = 32'(DEPTH);

    // Control word slots following the two per-symbol tables.
    localparam int CTL_EPS_BEG = 0;
    localparam int CTL_EPS_BLK = 1;
    localparam int CTL_EPS_END = 2;
    localparam int CTL_INIT    = 3;
    localparam int CTL_ACCEPT  = 4;

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_MATCH = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_EXEC  = 3'd1,
        ST_FETCH = 3'd2,
        ST_ALPHA = 3'd3,
        ST_EPS   = 3'd4
    } fsm_t;

    fsm_t               fsm_q, fsm_d;
    logic [1:0]         op_q, op_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [STATE_W-1:0] data_q, data_d;
    logic [STATE_W-1:0] s1_q, s1_d;
    logic [STATE_W-1:0] nfa_state_q, nfa_state_d;
    logic               acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    // Per-symbol tables held in block RAM with a registered read port.
    logic [STATE_W-1:0] rep_mem  [NSYM];
    logic [STATE_W-1:0] move_mem [NSYM];
    logic [STATE_W-1:0] rep_rd_q;
    logic [STATE_W-1:0] move_rd_q;

    // Control words, one register each (read every MATCH, so kept in fabric).
    logic [STATE_W-1:0] ctl_word [N_CTL];

    logic [31:0]        idx_ext;
    logic               idx_in_range;
    logic               wr_en;
    logic               rep_we;
    logic               move_we;
    logic [31:0]        ctl_sel;
    logic [CHAR_W-1:0]  mem_waddr;
    logic [CHAR_W-1:0]  sym;

    logic [STATE_W-1:0] alpha_next;
    logic [STATE_W-1:0] eps_high;
    logic [STATE_W-1:0] eps_low;
    logic [STATE_W-1:0] eps_next;
    logic               eps_acc;

    // Address low bits below the word granularity carry no information.
    generate
        if (ADDR_SHIFT > 0) begin : g_addr_lsbs
            logic unused_addr_lsbs;
            assign unused_addr_lsbs = ^inp_control[ADDR_SHIFT-1:0];
        end
    endgenerate

    // Write decode: tables share the low index bits because NSYM is a power of two.
    assign idx_ext      = 32'(idx_q);
    assign idx_in_range = (idx_ext < DEPTH_U);
    assign wr_en        = (fsm_q == ST_EXEC) && (op_q == OP_WRITE) && idx_in_range;
    assign rep_we       = wr_en && (idx_ext < NSYM_U);
    assign move_we      = wr_en && (idx_ext >= NSYM_U) && (idx_ext < TBL_END);
    assign ctl_sel      = idx_ext - TBL_END;
    assign mem_waddr    = idx_q[CHAR_W-1:0];
    assign sym          = data_q[CHAR_W-1:0];

    // REP_POS table: write from EXEC, read address is the latched symbol.
    always_ff @(posedge clk) begin
        if (rep_we) begin
            rep_mem[mem_waddr] <= data_q;
        end
        rep_rd_q <= rep_mem[sym];
    end

    // MOVE table: same organisation as REP_POS, separate array so both
    // entries for a symbol are fetched in the same cycle.
    always_ff @(posedge clk) begin
        if (move_we) begin
            move_mem[mem_waddr] <= data_q;
        end
        move_rd_q <= move_mem[sym];
    end

    // One register per control word; contents survive reset like the tables.
    genvar gi;
    generate
        for (gi = 0; gi < N_CTL; gi++) begin : g_ctl
            logic               we;
            logic [STATE_W-1:0] word_q;
            assign we = wr_en && (idx_ext >= TBL_END) && (ctl_sel == 32'(gi));
            // Load this control word when its address is written.
            always_ff @(posedge clk) begin
                if (we) begin
                    word_q <= data_q;
                end
            end
            assign ctl_word[gi] = word_q;
        end
    endgenerate

    // Alpha step: shift-in with INIT gated by MOVE, self-loops via REP_POS.
    assign alpha_next = (((nfa_state_q << 1) | ctl_word[CTL_INIT]) & move_rd_q)
                      | (nfa_state_q & rep_rd_q);

    // Epsilon closure: the subtraction ripples a borrow from each block
    // start up to its end, flagging every position reachable by skipping.
    assign eps_high = s1_q | ctl_word[CTL_EPS_END];
    assign eps_low  = eps_high - ctl_word[CTL_EPS_BEG];
    assign eps_next = (ctl_word[CTL_EPS_BLK] & (~eps_low ^ eps_high)) | s1_q;
    assign eps_acc  = |(eps_next & ctl_word[CTL_ACCEPT]);

    // Next-state and datapath update for the command sequencer.
    always_comb begin
        fsm_d       = fsm_q;
        op_d        = op_q;
        idx_d       = idx_q;
        data_d      = data_q;
        s1_d        = s1_q;
        nfa_state_d = nfa_state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        case (fsm_q)
            ST_IDLE: begin
                if (data_valid) begin
                    op_d   = inp_control[15:14];
                    idx_d  = inp_control[13:ADDR_SHIFT];
                    data_d = inp_data;
                    fsm_d  = (inp_control[15:14] == OP_MATCH) ? ST_FETCH : ST_EXEC;
                end
            end
            ST_EXEC: begin
                fsm_d  = ST_IDLE;
                done_d = 1'b1;
                acc_d  = 1'b0;
                if (op_q == OP_WRITE) begin
                    err_d = !idx_in_range;
                end
                if (op_q == OP_CLEAR) begin
                    nfa_state_d = '0;
                    cnt_d       = '0;
                end
            end
            ST_FETCH: begin
                fsm_d = ST_ALPHA;
            end
            ST_ALPHA: begin
                s1_d  = alpha_next;
                fsm_d = ST_EPS;
            end
            ST_EPS: begin
                nfa_state_d = eps_next;
                acc_d       = eps_acc;
                if (eps_acc && (cnt_q != {CNT_W{1'b1}})) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                done_d = 1'b1;
                fsm_d  = ST_IDLE;
            end
            default: begin
                fsm_d = ST_IDLE;
            end
        endcase
    end

    // State register; reset abandons any command in flight without a done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_q       <= ST_IDLE;
            op_q        <= OP_NOP;
            idx_q       <= '0;
            data_q      <= '0;
            s1_q        <= '0;
            nfa_state_q <= '0;
            acc_q       <= 1'b0;
            cnt_q       <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            op_q        <= op_d;
            idx_q       <= idx_d;
            data_q      <= data_d;
            s1_q        <= s1_d;
            nfa_state_q <= nfa_state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign ready_status    = (fsm_q == ST_IDLE);
    assign done_status     = done_q;
    assign accepted_status = acc_q;
    assign error_status    = err_q;
    assign match_count     = cnt_q;

endmodule

// File: tb/tb_pmm_stream_matcher.sv
`timescale 1ns/1ps
// Directed bench for pmm_stream_matcher: a memory-map model of the tables,
// a per-command result model, and a per-cycle compare process.
module tb_pmm_stream_matcher;

    localparam int STATE_W    = 64;
    localparam int CHAR_W     = 8;
    localparam int ADDR_SHIFT = 3;
    localparam int CNT_W      = 16;
    localparam int NSYM       = 256;
    localparam int DEPTH      = 2 * NSYM + 5;
    localparam int W_EPS_BEG  = 2 * NSYM;
    localparam int W_EPS_BLK  = 2 * NSYM + 1;
    localparam int W_EPS_END  = 2 * NSYM + 2;
    localparam int W_INIT     = 2 * NSYM + 3;
    localparam int W_ACCEPT   = 2 * NSYM + 4;

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_MATCH = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic [STATE_W-1:0] inp_data = '0;
    logic [15:0]        inp_control = '0;
    logic               data_valid = 1'b0;
    logic               ready_status, done_status, accepted_status, error_status;
    logic [CNT_W-1:0]   match_count;
    logic               ready2, done2, acc2, err2;
    logic [1:0]         cnt2;

    pmm_stream_matcher #(.STATE_W(STATE_W), .CHAR_W(CHAR_W), .ADDR_SHIFT(ADDR_SHIFT), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .inp_data(inp_data), .inp_control(inp_control),
        .data_valid(data_valid), .ready_status(ready_status), .done_status(done_status),
        .accepted_status(accepted_status), .error_status(error_status), .match_count(match_count)
    );

    // Narrow-counter copy fed the same commands, to observe saturation.
    pmm_stream_matcher #(.STATE_W(STATE_W), .CHAR_W(CHAR_W), .ADDR_SHIFT(ADDR_SHIFT), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .inp_data(inp_data), .inp_control(inp_control),
        .data_valid(data_valid), .ready_status(ready2), .done_status(done2),
        .accepted_status(acc2), .error_status(err2), .match_count(cnt2)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Model: the memory map as the spec lays it out, plus NFA state and count.
    logic [63:0] m_mem [DEPTH];
    logic [63:0] m_state = '0;
    int          m_cnt = 0;

    // Result of the command in flight, and what the outputs currently show.
    int          done_cyc = -100;
    logic        p_acc = 1'b0, p_err = 1'b0, p_chk_state = 1'b0;
    int          p_cnt = 0;
    logic [63:0] p_state = '0;
    logic        shown_acc = 1'b0;
    int          shown_cnt = 0;

    bit cmp_en = 0;
    int checks = 0;
    int errors = 0;
    int txn_n = 0;

    function automatic int sat(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Per-cycle comparison of every output against the model's timeline.
    always @(negedge clk) begin : compare
        bit busy, dn;
        if (cmp_en && !reset) begin
            busy = (cyc < done_cyc);
            dn   = (cyc == done_cyc);
            chk("ready", 64'(ready_status), 64'(!busy));
            chk("done", 64'(done_status), 64'(dn));
            chk("error", 64'(error_status), 64'(dn && p_err));
            chk("done_cnt2dut", 64'(done2), 64'(dn));
            if (dn) begin
                shown_acc = p_acc;
                shown_cnt = p_cnt;
                if (p_chk_state) chk("state", dut.nfa_state_q, p_state);
            end
            chk("accepted", 64'(accepted_status), 64'(shown_acc));
            chk("match_count", 64'(match_count), 64'(sat(shown_cnt, CNT_W)));
            chk("match_count_w2", 64'(cnt2), 64'(sat(shown_cnt, 2)));
        end
    end

    // Issue one command as soon as the model says the block is free; called
    // and returning at #1 after a rising edge.
    task automatic issue(input logic [1:0] op, input int idx, input logic [63:0] data);
        int          lat, sym, acc_cyc;
        logic [63:0] s1, high, low;
        while (cyc < done_cyc) begin
            @(posedge clk); #1;
        end
        inp_control = {op, 14'(idx << ADDR_SHIFT)};
        inp_data    = data;
        data_valid  = 1'b1;
        @(posedge clk); #1;
        data_valid  = 1'b0;
        acc_cyc     = cyc;
        lat         = 1;
        p_acc       = 1'b0;
        p_err       = 1'b0;
        p_chk_state = 1'b0;
        case (op)
            OP_WRITE: begin
                if (idx < DEPTH) m_mem[idx] = data;
                else p_err = 1'b1;
            end
            OP_MATCH: begin
                lat  = 3;
                sym  = int'(data[CHAR_W-1:0]);
                s1   = (((m_state << 1) | m_mem[W_INIT]) & m_mem[NSYM + sym]) | (m_state & m_mem[sym]);
                high = s1 | m_mem[W_EPS_END];
                low  = high - m_mem[W_EPS_BEG];
                m_state = (m_mem[W_EPS_BLK] & (~low ^ high)) | s1;
                p_acc = |(m_state & m_mem[W_ACCEPT]);
                if (p_acc) m_cnt++;
                p_chk_state = 1'b1;
            end
            OP_CLEAR: begin
                m_state = '0;
                m_cnt   = 0;
                p_chk_state = 1'b1;
            end
            default: ;
        endcase
        p_cnt    = m_cnt;
        p_state  = m_state;
        done_cyc = acc_cyc + lat;
        txn_n++;
        $display("txn %0d: cycle %0d op=%0d idx=%0d data=%h exp_acc=%0d exp_cnt=%0d exp_state=%h",
                 txn_n, acc_cyc, op, idx, data, p_acc, m_cnt, m_state);
    endtask

    task automatic wait_idle();
        while (cyc <= done_cyc) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic match_sym(input int s);
        issue(OP_MATCH, 0, {$urandom, 24'($urandom), 8'(s)});
    endtask

    initial begin : watchdog
        #2000000;
        errors++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [63:0] rnd;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        cmp_en = 1;

        // NOP: done exactly one cycle after acceptance.
        issue(OP_NOP, 0, '0);
        @(posedge clk); #1;
        chk("nop_done", 64'(done_status), 64'd1);
        chk("nop_ready", 64'(ready_status), 64'd1);
        chk("nop_acc", 64'(accepted_status), 64'd0);
        wait_idle();

        // Zero the whole map, then build "ab".
        for (int i = 0; i < DEPTH; i++) issue(OP_WRITE, i, '0);
        issue(OP_WRITE, W_INIT, 64'h1);
        issue(OP_WRITE, NSYM + 97, 64'h1);
        issue(OP_WRITE, NSYM + 98, 64'h2);
        issue(OP_WRITE, W_ACCEPT, 64'h2);
        issue(OP_CLEAR, 0, '0);
        match_sym(97);
        wait_idle();
        chk("ab_state_a", dut.nfa_state_q, 64'h1);
        chk("ab_acc_a", 64'(accepted_status), 64'd0);
        match_sym(98);
        wait_idle();
        chk("ab_state_b", dut.nfa_state_q, 64'h2);
        chk("ab_acc_b", 64'(accepted_status), 64'd1);
        chk("ab_count", 64'(match_count), 64'd1);

        // a+b: self-loop on 'a'; CLEAR zeroes the count, so one accept follows.
        issue(OP_WRITE, 97, 64'h1);
        issue(OP_CLEAR, 0, '0);
        match_sym(97);
        match_sym(97);
        match_sym(98);
        wait_idle();
        chk("aab_acc", 64'(accepted_status), 64'd1);
        match_sym(99);
        wait_idle();
        chk("c_acc", 64'(accepted_status), 64'd0);
        chk("c_state", dut.nfa_state_q, 64'h0);
        chk("c_count", 64'(match_count), 64'd1);

        // Out-of-range write flags an error and changes nothing; 516 is ACCEPT.
        issue(OP_WRITE, DEPTH, '1);
        @(posedge clk); #1;
        chk("oor_error", 64'(error_status), 64'd1);
        chk("oor_done", 64'(done_status), 64'd1);
        issue(OP_WRITE, DEPTH - 1, 64'h1);
        @(posedge clk); #1;
        chk("acc_wr_error", 64'(error_status), 64'd0);
        match_sym(97);
        wait_idle();
        chk("new_accept_acc", 64'(accepted_status), 64'd1);
        chk("new_accept_count", 64'(match_count), 64'd2);

        // Back-to-back accepting matches; the 2-bit counter saturates at 3.
        issue(OP_WRITE, W_ACCEPT, 64'h2);
        issue(OP_CLEAR, 0, '0);
        for (int i = 0; i < 4; i++) begin
            match_sym(97);
            match_sym(98);
        end
        wait_idle();
        chk("sat_count16", 64'(match_count), 64'd4);
        chk("sat_count2", 64'(cnt2), 64'd3);

        // Reset while the match is in ALPHA.
        match_sym(97);
        @(posedge clk); #1;
        reset = 1'b1;
        m_state = '0; m_cnt = 0; shown_acc = 1'b0; shown_cnt = 0; done_cyc = -100;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("rst_ready", 64'(ready_status), 64'd1);
        chk("rst_done", 64'(done_status), 64'd0);
        chk("rst_state", dut.nfa_state_q, 64'h0);
        chk("rst_count", 64'(match_count), 64'd0);
        repeat (4) begin
            @(posedge clk); #1;
        end

        // Optional position: "a b? c" with epsilon block over bits 1.
        issue(OP_WRITE, 97, 64'h0);
        issue(OP_WRITE, NSYM + 99, 64'h4);
        issue(OP_WRITE, W_EPS_BEG, 64'h1);
        issue(OP_WRITE, W_EPS_BLK, 64'h2);
        issue(OP_WRITE, W_EPS_END, 64'h2);
        issue(OP_WRITE, W_ACCEPT, 64'h4);
        issue(OP_CLEAR, 0, '0);
        match_sym(97);
        match_sym(99);
        wait_idle();
        chk("ac_acc", 64'(accepted_status), 64'd1);
        for (int i = 0; i < 500; i++) match_sym(97 + $urandom_range(0, 3));

        // Dense random masks exercise long borrow chains in the closure.
        for (int s = 97; s <= 100; s++) begin
            rnd = {$urandom, $urandom};
            issue(OP_WRITE, s, rnd);
            rnd = {$urandom, $urandom};
            issue(OP_WRITE, NSYM + s, rnd);
        end
        for (int w = W_EPS_BEG; w <= W_ACCEPT; w++) begin
            rnd = {$urandom, $urandom};
            issue(OP_WRITE, w, rnd);
        end
        for (int i = 0; i < 500; i++) match_sym(97 + $urandom_range(0, 3));
        wait_idle();
        repeat (2) begin
            @(posedge clk); #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
